muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV64M/RV32M multiply/divide unit for the execute stage. Takes the M-extension operations out of the single-cycle ALU into a shift-add / restoring-divide engine with a valid/ready handshake. The unit is parametrised in XLEN and in bits retired per cycle. It covers the RISC-V divide-by-zero and overflow cases, and it supports flushing a pipeline mid-operation.

## Interface
- XLEN, 64: operand width, 32 or 64; word (W) ops are legal only when XLEN=64.
- STEP, 1: quotient/multiplier bits retired per CALC cycle, 1, 2 or 4; must divide 32.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abandons any in-flight operation.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- in_op  in  4  operation code, `md_op_e`.
- in_rs1  in  XLEN  dividend / multiplicand.
- in_rs2  in  XLEN  divisor / multiplier.
- in_tag  in  5  destination register, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_result  out  XLEN  result.
- out_tag  out  5  tag captured at accept.

## Operation
- Operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
  - An illegal or W code with XLEN=32 is treated as MUL.
- FSM states IDLE, CALC, ADJUST, DONE.
  - IDLE → CALC on accept, i.e. `in_valid && in_ready`.
  - IDLE → DONE on accept of a special case.
  - CALC → ADJUST when the step counter reaches N/STEP−1.
  - ADJUST → DONE.
  - DONE → IDLE on `out_ready`.
- `in_ready` = (state==IDLE). There is no accept in the same cycle as a DONE handoff.
- N = 32 for W ops, XLEN otherwise.
- W ops use operand bits [31:0] only.
  - Signed W ops sign-extend those bits to form the operands.
  - DIVUW/REMUW zero-extend them.
- Operands are latched at accept and converted to magnitudes. The result sign is recorded:
  - MULH: product negative iff signs differ.
  - MULHSU: sign follows rs1 only.
  - DIV: quotient negative iff signs differ.
  - REM: remainder takes the sign of the dividend.
- CALC performs STEP iterations per cycle on a 2N-bit accumulator.
  - Multiply: shift-add.
  - Divide: restoring.
- ADJUST negates the result if the recorded sign is negative, then selects:
  - low N bits for MUL and MULW;
  - high N bits for MULH, MULHSU and MULHU;
  - quotient or remainder for the divide ops.
- W results are sign-extended from bit 31 to XLEN, including DIVUW and REMUW.
- Special cases are decided at accept, skip CALC and give out_valid 1 cycle after accept:
  - divisor zero: quotient = all ones, remainder = dividend (after W extension);
  - signed overflow, dividend = −2^(N−1) and divisor = −1: quotient = dividend, remainder = 0;
  - multiply with either operand zero: result 0.
- `flush` has priority over everything except rst.
  - State → IDLE and out_valid → 0 next cycle, including a held DONE result.
  - A request offered in the flush cycle is not accepted.
- rst behaves identically to flush. After reset all datapath registers are 0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_result=0, out_tag=0.
- Latency from the accept edge to out_valid=1:
  - normal operation: N/STEP + 2 cycles, so 66 for a 64-bit op with STEP=1 and 10 for a W op with STEP=4;
  - special case: 1 cycle.
- out_result and out_tag are stable while out_valid=1 and out_ready=0.
- Throughput: one operation in flight; the next accept is possible the cycle after the DONE handoff.
- No combinational path from in_* to out_*.
- out_ready is only sampled in DONE.

## Structure
- Package `muldiv_pkg`:
  - `md_op_e` (4-bit enum);
  - `md_state_e`;
  - helper functions `is_mul`, `is_word`, `is_signed_a`, `is_signed_b`.
- The ALU decoder maps its `i_mul..i_remuw` codes onto `md_op_e`.
- Sub-module `muldiv_step`: combinational, applies STEP shift-add or restoring-subtract iterations to {acc, operand, mode}. It is instantiated once; the FSM and sign/adjust logic stay in `muldiv_unit`.

## Test plan
- MUL 7×(−3), XLEN=64 → out_result 0xFFFF_FFFF_FFFF_FFEB after 66 cycles (STEP=1).
- MULHU 0xFFFF_FFFF_FFFF_FFFF×2 → 1.
- MULH −1×−1 → 0.
- MULHSU −1×2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV −7/2 → −3.
- REM −7/2 → −1.
- DIVU 0/5 → 0.
- DIV 5/0 → all ones and REM 5/0 → 5, each 1 cycle after accept.
- DIV 0x8000_0000_0000_0000/−1 → 0x8000_0000_0000_0000 and REM → 0.
- DIVUW rs1=0xFFFF_FFFF, rs2=1 → 0xFFFF_FFFF_FFFF_FFFF.
- ADDW-style sign-extension check on REMW 0x8000_0000 % 3 → 0xFFFF_FFFF_FFFF_FFFE.
- flush at CALC cycle 10 → out_valid never rises, in_ready=1 the next cycle.
- A back-to-back request after the flush completes correctly.
- Hold out_ready=0 for 20 cycles in DONE → result and tag stable, in_ready=0 throughout.
- rst mid-CALC → all outputs at reset values next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the iterative M-extension multiply/divide unit.
// The md_op_e ordering mirrors the ALU decoder's i_mul..i_remuw codes.
package muldiv_pkg;

    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_DIV    = 4'd4,
        MD_DIVU   = 4'd5,
        MD_REM    = 4'd6,
        MD_REMU   = 4'd7,
        MD_MULW   = 4'd8,
        MD_DIVW   = 4'd9,
        MD_DIVUW  = 4'd10,
        MD_REMW   = 4'd11,
        MD_REMUW  = 4'd12
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_ADJUST = 2'd2,
        S_DONE   = 2'd3
    } md_state_e;

    localparam int TAG_W = 5;

    function automatic logic is_mul(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_MULW};
    endfunction

    function automatic logic is_word(input md_op_e op);
        return op inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
    endfunction

    function automatic logic is_signed_a(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM, MD_MULW, MD_DIVW, MD_REMW};
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM, MD_MULW, MD_DIVW, MD_REMW};
    endfunction

    function automatic logic is_rem(input md_op_e op);
        return op inside {MD_REM, MD_REMU, MD_REMW, MD_REMUW};
    endfunction

    function automatic logic is_high(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational core: STEP shift-add (multiply) or restoring-subtract (divide)
// iterations on the 2*XLEN accumulator {hi, lo}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int STEP = 1
) (
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    input  logic              div_mode,
    output logic [2*XLEN-1:0] acc_out
);

    logic [2*XLEN-1:0] acc_v;
    logic [2*XLEN:0]   shl;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     diff;

    always_comb begin
        acc_v = acc_in;
        shl   = '0;
        sum   = '0;
        diff  = '0;
        for (int i = 0; i < STEP; i++) begin
            if (div_mode) begin
                // remainder < divisor keeps a non-negative diff below 2^XLEN, so bit XLEN is the borrow
                shl  = {acc_v, 1'b0};
                diff = shl[2*XLEN:XLEN] - {1'b0, opnd};
                if (!diff[XLEN]) begin
                    acc_v = {diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
                end else begin
                    acc_v = shl[2*XLEN-1:0];
                end
            end else begin
                sum   = {1'b0, acc_v[2*XLEN-1:XLEN]} + (acc_v[0] ? {1'b0, opnd} : '0);
                acc_v = {sum, acc_v[XLEN-1:1]};
            end
        end
        acc_out = acc_v;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M/RV32M multiply/divide unit: operands are latched as magnitudes,
// iterated in muldiv_step, then sign-corrected and selected in ADJUST.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CNT_W = $clog2(XLEN / STEP);

    function automatic md_op_e norm_op(input logic [3:0] code);
        md_op_e op;
        if (code > 4'(MD_REMUW)) return MD_MUL;
        op = md_op_e'(code);
        if (XLEN == 32 && is_word(op)) op = MD_MUL;
        return op;
    endfunction

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        logic signed [32:0] v_s;
        v_s = {sgn & v[31], v};
        return XLEN'(v_s);
    endfunction

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
        logic signed [XLEN-1:0] v_s;
        v_s = v;
        return en ? -v_s : v_s;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic en);
        logic signed [2*XLEN-1:0] v_s;
        v_s = v;
        return en ? -v_s : v_s;
    endfunction

    md_state_e         state_q, state_nxt;
    logic              accept;

    md_op_e            op_in;
    logic              word_in, sa_in, sb_in, a_neg, b_neg;
    logic              div_zero, div_ovf, mul_zero, special_in;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val, special_res;

    md_op_e            op_p0;
    logic              neg_p0;
    logic [CNT_W-1:0]  cnt_p0, last_cnt;
    logic [2*XLEN-1:0] acc_p0, acc_nxt;
    logic [XLEN-1:0]   opnd_p0;
    logic              word_p0, div_mode;

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, adj_res;

    logic [XLEN-1:0]   res_p1;
    logic [TAG_W-1:0]  tag_p1;

    // A request offered during flush is dropped even if the unit is idle
    assign accept = in_valid && (state_q == S_IDLE) && !flush;

    // ---- accept: operand extension, magnitudes and special-case detection
    always_comb begin
        op_in   = norm_op(in_op);
        word_in = is_word(op_in);
        sa_in   = is_signed_a(op_in);
        sb_in   = is_signed_b(op_in);
        a_ext   = word_in ? ext32(in_rs1[31:0], sa_in) : in_rs1;
        b_ext   = word_in ? ext32(in_rs2[31:0], sb_in) : in_rs2;
        a_neg   = sa_in && a_ext[XLEN-1];
        b_neg   = sb_in && b_ext[XLEN-1];
        a_mag   = neg_x(a_ext, a_neg);
        b_mag   = neg_x(b_ext, b_neg);
        min_val = word_in ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};

        div_zero   = !is_mul(op_in) && (b_ext == '0);
        div_ovf    = !is_mul(op_in) && sa_in && (a_ext == min_val) && (b_ext == '1);
        mul_zero   = is_mul(op_in) && ((a_ext == '0) || (b_ext == '0));
        special_in = div_zero || div_ovf || mul_zero;

        special_res = '0;
        if (div_zero) begin
            special_res = is_rem(op_in) ? a_ext : '1;
        end else if (div_ovf) begin
            special_res = is_rem(op_in) ? '0 : a_ext;
        end
        if (word_in) special_res = ext32(special_res[31:0], 1'b1);
    end

    assign word_p0  = is_word(op_p0);
    assign div_mode = !is_mul(op_p0);
    assign last_cnt = word_p0 ? CNT_W'(32 / STEP - 1) : CNT_W'(XLEN / STEP - 1);

    muldiv_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .acc_in   (acc_p0),
        .opnd     (opnd_p0),
        .div_mode (div_mode),
        .acc_out  (acc_nxt)
    );

    // ---- adjust: sign correction and result selection
    always_comb begin
        // 32-step multiplies leave the product aligned 32 bits up
        prod   = word_p0 ? (acc_p0 >> 32) : acc_p0;
        prod_s = neg_2x(prod, neg_p0);
        quo_s  = neg_x(acc_p0[XLEN-1:0], neg_p0);
        rem_s  = neg_x(acc_p0[2*XLEN-1:XLEN], neg_p0);
        if (is_mul(op_p0)) begin
            adj_res = is_high(op_p0) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end else begin
            adj_res = is_rem(op_p0) ? rem_s : quo_s;
        end
        if (word_p0) adj_res = ext32(adj_res[31:0], 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_nxt = special_in ? S_DONE : S_CALC;
            S_CALC:   if (cnt_p0 == last_cnt) state_nxt = S_ADJUST;
            S_ADJUST: state_nxt = S_DONE;
            S_DONE:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_p0   <= MD_MUL;
            neg_p0  <= 1'b0;
            cnt_p0  <= '0;
            acc_p0  <= '0;
            opnd_p0 <= '0;
            res_p1  <= '0;
            tag_p1  <= '0;
        end else if (accept) begin
            op_p0  <= op_in;
            neg_p0 <= is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
            cnt_p0 <= '0;
            tag_p1 <= in_tag;
            if (is_mul(op_in)) begin
                acc_p0  <= {{XLEN{1'b0}}, b_mag};
                opnd_p0 <= a_mag;
            end else begin
                // W dividends start in the upper half of lo so 32 steps consume them
                acc_p0  <= {{XLEN{1'b0}}, (word_in ? (a_mag << (XLEN - 32)) : a_mag)};
                opnd_p0 <= b_mag;
            end
            if (special_in) res_p1 <= special_res;
        end else if (!flush) begin
            if (state_q == S_CALC) begin
                acc_p0 <= acc_nxt;
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end else if (state_q == S_ADJUST) begin
                res_p1 <= adj_res;
            end
        end
    end

    assign out_result = res_p1;
    assign out_tag    = tag_p1;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=64, STEP=1): vector table plus
// flush / hold / reset sequences, checked through an expected-result queue.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 64;
    localparam int STEP = 1;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, out_ready;
    logic            in_ready, out_valid;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_rs1, in_rs2, out_result;
    logic [4:0]      in_tag, out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] result;
        logic [4:0]  tag;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    muldiv_unit #(.XLEN(XLEN), .STEP(STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time limit, required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ending: 0 = hand off with out_ready, 1 = drop the held result with flush
    task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp,
                          input int lat, input int hold, input int ending);
        exp_t e;
        int   cyc;
        bit   seen;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
        e.result = exp; e.tag = tag; e.lat = lat;
        sb_q.push_back(e);
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            seen = out_valid;
        end
        e = sb_q.pop_front();
        check({name, "_latency"}, 64'(cyc), 64'(e.lat));
        if (!seen) return;
        check({name, "_result"}, out_result, e.result);
        check({name, "_tag"}, 64'(out_tag), 64'(e.tag));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({name, "_hold_result"}, out_result, e.result);
            check({name, "_hold_tag"}, 64'(out_tag), 64'(e.tag));
            check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        if (ending == 0) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end else begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        check({name, "_after_valid"}, 64'(out_valid), 64'd0);
        check({name, "_after_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        bit bad;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;

        vecs.push_back(mk(4'(MD_MUL),    64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 66));
        vecs.push_back(mk(4'(MD_MULHU),  ONES, 64'd2, 64'd1, 66));
        vecs.push_back(mk(4'(MD_MULH),   ONES, ONES, 64'd0, 66));
        vecs.push_back(mk(4'(MD_MULHSU), ONES, 64'd2, ONES, 66));
        vecs.push_back(mk(4'(MD_DIV),    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66));
        vecs.push_back(mk(4'(MD_REM),    -64'sd7, 64'd2, ONES, 66));
        vecs.push_back(mk(4'(MD_DIVU),   64'd0, 64'd5, 64'd0, 66));
        vecs.push_back(mk(4'(MD_DIV),    64'd5, 64'd0, ONES, 1));
        vecs.push_back(mk(4'(MD_REM),    64'd5, 64'd0, 64'd5, 1));
        vecs.push_back(mk(4'(MD_DIV),    64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1));
        vecs.push_back(mk(4'(MD_REM),    64'h8000_0000_0000_0000, ONES, 64'd0, 1));
        vecs.push_back(mk(4'(MD_DIVUW),  64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 34));
        vecs.push_back(mk(4'(MD_REMW),   64'h0000_0000_8000_0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 34));
        vecs.push_back(mk(4'(MD_MUL),    64'd0, 64'd123, 64'd0, 1));
        vecs.push_back(mk(4'(MD_MULW),   64'hFFFF_FFFF_0000_0003, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFD, 34));
        vecs.push_back(mk(4'(MD_REMUW),  64'h0000_0000_8000_0007, 64'd0, 64'hFFFF_FFFF_8000_0007, 1));
        vecs.push_back(mk(4'(MD_DIVU),   ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 66));
        vecs.push_back(mk(4'(MD_MULHU),  64'h8000_0000_0000_0000, 64'd4, 64'd2, 66));
        vecs.push_back(mk(4'd15,         64'd6, 64'd7, 64'd42, 66));
        vecs.push_back(mk(4'(MD_DIVW),   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", out_result, 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
                   vecs[i].exp, vecs[i].lat, 0, 0);
        end

        // flush at the tenth CALC cycle, then a request straight after
        in_valid = 1'b1; in_op = 4'(MD_DIVU); in_rs1 = 64'd100; in_rs2 = 64'd7; in_tag = 5'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_calc_in_ready", 64'(in_ready), 64'd1);
        check("flush_calc_out_valid", 64'(out_valid), 64'd0);
        run_op("after_flush", 4'(MD_MUL), 64'd7, -64'sd3, 5'd4, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0, 0);

        // request offered together with flush while idle must be ignored
        flush = 1'b1; in_valid = 1'b1; in_op = 4'(MD_DIV); in_rs1 = 64'd5; in_rs2 = 64'd0; in_tag = 5'd7;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_in_ready", 64'(in_ready), 64'd1);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) bad = 1'b1;
            @(negedge clk);
        end
        check("flush_idle_no_valid", 64'(bad), 64'd0);

        run_op("hold_done", 4'(MD_DIVW), 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd21,
               64'hFFFF_FFFF_FFFF_FFFD, 34, 20, 0);
        run_op("flush_done", 4'(MD_DIVU), 64'd1000, 64'd7, 5'd17, 64'd142, 66, 2, 1);

        // reset in the middle of CALC
        in_valid = 1'b1; in_op = 4'(MD_MUL); in_rs1 = 64'd3; in_rs2 = 64'd5; in_tag = 5'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_calc_in_ready", 64'(in_ready), 64'd1);
        check("rst_calc_out_valid", 64'(out_valid), 64'd0);
        check("rst_calc_out_result", out_result, 64'd0);
        check("rst_calc_out_tag", 64'(out_tag), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
